ex_stage: RTL
=============

Name: ex_stage

Overview:
Execute stage of the RV32IM 5-stage pipeline, between ID/forwarding and the MEM stage. It computes ALU results in one cycle and MUL/DIV results in a multi-cycle iterative unit, stalling the front end while that unit is busy. It drives the EX/MEM pipeline register consumed by MEM. It holds that register while MEM reports a cache miss.

Parameters:
XLEN, 32, datapath width (only 32 supported)
MD_CYCLES, 32, iterations of the mul/div unit

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
pc_4_ID  in  32  PC+4 of the instruction in ID/EX
op_a_ID  in  32  ALU operand A (already forwarded/muxed)
op_b_ID  in  32  ALU operand B (already forwarded/muxed)
rd2_ID  in  32  store data
reg_wb_addr_ID  in  5  destination register
ctrl_mem_r_ID / ctrl_mem_w_ID  in  1 each  load / store
funct3_ID  in  3  memory width, or mul/div select
ctrl_reg_write_ID  in  1  register write enable
ctrl_wb_reg_src_ID  in  2  write-back source select
alu_op_ID  in  4  ALU operation
md_ID  in  1  instruction is RV32M
miss  in  1  MEM-stage miss; hold EX/MEM
stall_EX  out  1  hold IF/ID/ID-EX this cycle (combinational)
pc_4_EX, alu_out_EX, rd2_EX  out  32 each  registered
reg_wb_addr_EX  out  5  registered
ctrl_mem_r_EX, ctrl_mem_w_EX, ctrl_reg_write_EX  out  1 each  registered
funct3_EX  out  3  registered
ctrl_wb_reg_src_EX  out  2  registered

Behaviour:
- Reset (rst=1 at edge): all registered outputs become 0, mul/div FSM goes to IDLE, iteration counter is 0, and any in-flight operation is discarded. stall_EX is 0 while rst=1.
- ALU operations, selected by alu_op_ID:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B.
  - Codes 11-15 produce 0.
  - Shift amount is op_b[4:0]. Arithmetic wraps mod 2^32.
- Mul/div operations, selected by funct3_ID when md_ID=1: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU. Results are bit-exact to RV32M.
- FSM states are IDLE, BUSY, DONE.
  - IDLE: when md_ID=1 and miss=0, latch operands and op, clear the counter, go to BUSY.
  - IDLE shortcut for special cases: divisor=0, or signed overflow (0x80000000 / 0xFFFFFFFF) on DIV/REM, goes directly to DONE.
  - BUSY: one iteration per cycle. After iteration MD_CYCLES-1 go to DONE. BUSY keeps iterating even when miss=1.
  - DONE: if miss=0, capture the result into EX/MEM and go to IDLE. If miss=1, stay in DONE.
- Special-case results:
  - Division by zero: quotient 0xFFFFFFFF, remainder = dividend.
  - Signed overflow: quotient 0x80000000, remainder 0.
- stall_EX = miss | (state==BUSY) | (md_ID & state!=DONE).
- Latency:
  - ALU instruction: result appears at the next edge.
  - Normal mul/div: 33 stall cycles, with the result registered at the end of the DONE cycle (34 cycles in EX).
  - Special-case mul/div: 1 stall cycle.
- EX/MEM register update priority:
  - rst: load zeros.
  - else miss=1: hold all outputs.
  - else stall_EX=1 (mul/div pending): load a bubble (all zeros).
  - else: load the ID inputs, with alu_out_EX = ALU result or mul/div result.
- Unused fields pass through unchanged; rd2_EX = rd2_ID.
- Operands are latched at start, so changes on the ID inputs during BUSY are ignored. ID holds them anyway because of the stall.

Test Plan:
- ADD: op_a=5, op_b=0xFFFFFFF9, alu_op=0, rd=3, reg_write=1 -> next edge alu_out_EX=0xFFFFFFFE, reg_wb_addr_EX=3, stall_EX=0 throughout.
- MUL then MULHU, each with 0x00010000 x 0x00010000:
  - stall_EX high for 33 cycles each, with bubbles (all outputs 0) in EX/MEM meanwhile.
  - MUL result alu_out_EX=0x00000000; MULHU result 0x00000001.
  - MULH of 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000.
- DIV -7/2 (0xFFFFFFF9, 2) -> 0xFFFFFFFD. REM of the same -> 0xFFFFFFFF. DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
- Special cases, each with exactly 1 stall cycle:
  - DIVU 100/0 -> 0xFFFFFFFF.
  - REMU 100/0 -> 100.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM of the same -> 0.
- Miss handling:
  - miss=1 for 3 cycles with an ADD result in EX/MEM -> outputs unchanged, stall_EX=1. After miss drops, the next instruction loads on the next edge.
  - miss held across DONE of a MUL -> result captured in the first cycle with miss=0.
- Reset during the 10th BUSY cycle of a DIV -> next edge all outputs 0, stall_EX=0. Reissuing the DIV takes the full 33 stall cycles and gives the correct quotient.

Source files
------------

// File: rtl/ex_stage_if.sv
// Bus between ID/EX (operands and control in), the EX/MEM register (out) and the
// MEM-stage miss/stall handshake of the RV32IM execute stage.
interface ex_stage_if;
  logic [31:0] pc_4_ID;
  logic [31:0] op_a_ID;
  logic [31:0] op_b_ID;
  logic [31:0] rd2_ID;
  logic [4:0]  reg_wb_addr_ID;
  logic        ctrl_mem_r_ID;
  logic        ctrl_mem_w_ID;
  logic [2:0]  funct3_ID;
  logic        ctrl_reg_write_ID;
  logic [1:0]  ctrl_wb_reg_src_ID;
  logic [3:0]  alu_op_ID;
  logic        md_ID;
  logic        miss;
  logic        stall_EX;
  logic [31:0] pc_4_EX;
  logic [31:0] alu_out_EX;
  logic [31:0] rd2_EX;
  logic [4:0]  reg_wb_addr_EX;
  logic        ctrl_mem_r_EX;
  logic        ctrl_mem_w_EX;
  logic        ctrl_reg_write_EX;
  logic [2:0]  funct3_EX;
  logic [1:0]  ctrl_wb_reg_src_EX;

  modport master (
    output pc_4_ID, op_a_ID, op_b_ID, rd2_ID, reg_wb_addr_ID, ctrl_mem_r_ID,
           ctrl_mem_w_ID, funct3_ID, ctrl_reg_write_ID, ctrl_wb_reg_src_ID,
           alu_op_ID, md_ID, miss,
    input  stall_EX, pc_4_EX, alu_out_EX, rd2_EX, reg_wb_addr_EX, ctrl_mem_r_EX,
           ctrl_mem_w_EX, ctrl_reg_write_EX, funct3_EX, ctrl_wb_reg_src_EX
  );

  modport slave (
    input  pc_4_ID, op_a_ID, op_b_ID, rd2_ID, reg_wb_addr_ID, ctrl_mem_r_ID,
           ctrl_mem_w_ID, funct3_ID, ctrl_reg_write_ID, ctrl_wb_reg_src_ID,
           alu_op_ID, md_ID, miss,
    output stall_EX, pc_4_EX, alu_out_EX, rd2_EX, reg_wb_addr_EX, ctrl_mem_r_EX,
           ctrl_mem_w_EX, ctrl_reg_write_EX, funct3_EX, ctrl_wb_reg_src_EX
  );
endinterface

// File: rtl/ex_stage.sv
// RV32IM execute stage: single-cycle ALU, iterative shift-add / restoring-divide
// mul/div unit, and the EX/MEM pipeline register with miss hold and bubble insert.
//
// state | meaning
// IDLE  | no mul/div in flight; starts one when md_ID=1 and miss=0
// BUSY  | one multiply/divide iteration per cycle
// DONE  | result ready; written to EX/MEM on the first cycle without miss
module ex_stage #(
  parameter int XLEN      = 32,
  parameter int MD_CYCLES = 32
) (
  input logic     clk,
  input logic     rst,
  ex_stage_if.slave bus
);
  localparam int CW = $clog2(MD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_e;

  md_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] mb_q, mb_d;
  logic [63:0] acc_q, acc_d;
  logic        neg_lo_q, neg_lo_d, neg_r_q, neg_r_d;
  logic        sp_q, sp_d;
  logic [31:0] sp_res_q, sp_res_d;

  logic [31:0] pc_4_q, pc_4_d, alu_out_q, alu_out_d, rd2_q, rd2_d;
  logic [4:0]  rd_q, rd_d;
  logic        mem_r_q, mem_r_d, mem_w_q, mem_w_d, reg_write_q, reg_write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  wb_src_q, wb_src_d;

  logic [XLEN-1:0] alu_res;
  logic [4:0]  shamt;
  logic        stall;

  assign shamt = bus.op_b_ID[4:0];

  always_comb begin
    alu_res = '0;
    case (bus.alu_op_ID)
      4'd0:  alu_res = bus.op_a_ID + bus.op_b_ID;
      4'd1:  alu_res = bus.op_a_ID - bus.op_b_ID;
      4'd2:  alu_res = bus.op_a_ID << shamt;
      4'd3:  alu_res = {{(XLEN-1){1'b0}}, $signed(bus.op_a_ID) < $signed(bus.op_b_ID)};
      4'd4:  alu_res = {{(XLEN-1){1'b0}}, bus.op_a_ID < bus.op_b_ID};
      4'd5:  alu_res = bus.op_a_ID ^ bus.op_b_ID;
      4'd6:  alu_res = bus.op_a_ID >> shamt;
      4'd7:  alu_res = $signed(bus.op_a_ID) >>> shamt;
      4'd8:  alu_res = bus.op_a_ID | bus.op_b_ID;
      4'd9:  alu_res = bus.op_a_ID & bus.op_b_ID;
      4'd10: alu_res = bus.op_b_ID;
      default: alu_res = '0;
    endcase
  end

  // Operand conditioning at start: the iterative core works on magnitudes only.
  logic        is_div, a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [31:0] mag_a, mag_b;

  always_comb begin
    is_div   = bus.funct3_ID[2];
    a_signed = is_div ? ~bus.funct3_ID[0]
                      : (bus.funct3_ID == 3'd1) || (bus.funct3_ID == 3'd2);
    b_signed = is_div ? ~bus.funct3_ID[0] : (bus.funct3_ID == 3'd1);
    a_neg    = a_signed & bus.op_a_ID[31];
    b_neg    = b_signed & bus.op_b_ID[31];
    mag_a    = a_neg ? -bus.op_a_ID : bus.op_a_ID;
    mag_b    = b_neg ? -bus.op_b_ID : bus.op_b_ID;
    div_zero = is_div && (bus.op_b_ID == 32'd0);
    div_ovf  = is_div && !bus.funct3_ID[0] && (bus.op_a_ID == 32'h8000_0000) &&
               (bus.op_b_ID == 32'hFFFF_FFFF);
  end

  logic [32:0] mul_sum, div_sh, div_trial;
  logic [63:0] mul_next, div_next, prod;
  logic [31:0] quo, rem, md_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mb_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    div_sh    = acc_q[63:31];
    div_trial = div_sh - {1'b0, mb_q};
    div_next  = div_trial[32] ? {div_sh[31:0], acc_q[30:0], 1'b0}
                              : {div_trial[31:0], acc_q[30:0], 1'b1};
    prod      = neg_lo_q ? -acc_q : acc_q;
    quo       = neg_lo_q ? -acc_q[31:0] : acc_q[31:0];
    rem       = neg_r_q ? -acc_q[63:32] : acc_q[63:32];
    if (sp_q)             md_res = sp_res_q;
    else if (op_q == 3'd0) md_res = prod[31:0];
    else if (!op_q[2])    md_res = prod[63:32];
    else if (!op_q[1])    md_res = quo;
    else                  md_res = rem;
  end

  assign stall = !rst && (bus.miss || (state_q == BUSY) ||
                          (bus.md_ID && (state_q != DONE)));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    mb_d     = mb_q;
    acc_d    = acc_q;
    neg_lo_d = neg_lo_q;
    neg_r_d  = neg_r_q;
    sp_d     = sp_q;
    sp_res_d = sp_res_q;
    case (state_q)
      IDLE: if (bus.md_ID && !bus.miss) begin
        op_d     = bus.funct3_ID;
        mb_d     = mag_b;
        acc_d    = {32'd0, mag_a};
        neg_lo_d = a_neg ^ b_neg;
        neg_r_d  = a_neg;
        cnt_d    = '0;
        sp_d     = div_zero || div_ovf;
        if (div_zero) sp_res_d = bus.funct3_ID[1] ? bus.op_a_ID : 32'hFFFF_FFFF;
        else          sp_res_d = bus.funct3_ID[1] ? 32'd0 : 32'h8000_0000;
        state_d  = (div_zero || div_ovf) ? DONE : BUSY;
      end
      BUSY: begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(MD_CYCLES - 1)) state_d = DONE;
      end
      DONE: if (!bus.miss) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_4_d      = pc_4_q;
    alu_out_d   = alu_out_q;
    rd2_d       = rd2_q;
    rd_d        = rd_q;
    mem_r_d     = mem_r_q;
    mem_w_d     = mem_w_q;
    reg_write_d = reg_write_q;
    funct3_d    = funct3_q;
    wb_src_d    = wb_src_q;
    if (bus.miss) begin
      // hold everything while MEM is stalled on a miss
    end else if (stall) begin
      pc_4_d      = '0;
      alu_out_d   = '0;
      rd2_d       = '0;
      rd_d        = '0;
      mem_r_d     = 1'b0;
      mem_w_d     = 1'b0;
      reg_write_d = 1'b0;
      funct3_d    = '0;
      wb_src_d    = '0;
    end else begin
      pc_4_d      = bus.pc_4_ID;
      alu_out_d   = (state_q == DONE) ? md_res : alu_res;
      rd2_d       = bus.rd2_ID;
      rd_d        = bus.reg_wb_addr_ID;
      mem_r_d     = bus.ctrl_mem_r_ID;
      mem_w_d     = bus.ctrl_mem_w_ID;
      reg_write_d = bus.ctrl_reg_write_ID;
      funct3_d    = bus.funct3_ID;
      wb_src_d    = bus.ctrl_wb_reg_src_ID;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      mb_q        <= '0;
      acc_q       <= '0;
      neg_lo_q    <= 1'b0;
      neg_r_q     <= 1'b0;
      sp_q        <= 1'b0;
      sp_res_q    <= '0;
      pc_4_q      <= '0;
      alu_out_q   <= '0;
      rd2_q       <= '0;
      rd_q        <= '0;
      mem_r_q     <= 1'b0;
      mem_w_q     <= 1'b0;
      reg_write_q <= 1'b0;
      funct3_q    <= '0;
      wb_src_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      mb_q        <= mb_d;
      acc_q       <= acc_d;
      neg_lo_q    <= neg_lo_d;
      neg_r_q     <= neg_r_d;
      sp_q        <= sp_d;
      sp_res_q    <= sp_res_d;
      pc_4_q      <= pc_4_d;
      alu_out_q   <= alu_out_d;
      rd2_q       <= rd2_d;
      rd_q        <= rd_d;
      mem_r_q     <= mem_r_d;
      mem_w_q     <= mem_w_d;
      reg_write_q <= reg_write_d;
      funct3_q    <= funct3_d;
      wb_src_q    <= wb_src_d;
    end
  end

  assign bus.stall_EX           = stall;
  assign bus.pc_4_EX            = pc_4_q;
  assign bus.alu_out_EX         = alu_out_q;
  assign bus.rd2_EX             = rd2_q;
  assign bus.reg_wb_addr_EX     = rd_q;
  assign bus.ctrl_mem_r_EX      = mem_r_q;
  assign bus.ctrl_mem_w_EX      = mem_w_q;
  assign bus.ctrl_reg_write_EX  = reg_write_q;
  assign bus.funct3_EX          = funct3_q;
  assign bus.ctrl_wb_reg_src_EX = wb_src_q;
endmodule
